// File: rtl/adc_pipe_corrector.sv
// Digital-correction back end for a pipelined ADC: time-aligns per-stage codes, sums them with
// redundancy weights, saturates and counts clipped samples. Optional macro: ADC_PIPE_CORR_OFFSET_EN.
module adc_pipe_corrector #(
  parameter int NUM_STAGES     = 2,
  parameter int BITS_PER_STAGE = 2,
  parameter int REDUNDANCY     = 1,
  parameter int BITS_LAST      = 1,
  parameter int CNT_W          = 8,
  localparam int NUM_BITS      = NUM_STAGES*(BITS_PER_STAGE-REDUNDANCY)+BITS_LAST
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 valid_i,
  input  logic [NUM_STAGES*BITS_PER_STAGE-1:0] d_stage_i,
  input  logic [BITS_LAST-1:0]                 d_last_stage_i,
  input  logic                                 clr_cnt_i,
`ifdef ADC_PIPE_CORR_OFFSET_EN
  input  logic signed [NUM_BITS:0]             offset_i,
`endif
  output logic [NUM_BITS-1:0]                  d_o,
  output logic                                 valid_o,
  output logic                                 sat_o,
  output logic [CNT_W-1:0]                     sat_cnt_o
);

  localparam int IW = NUM_BITS + 1;
  localparam int SW = NUM_BITS + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic int shift_of(input int k);
    return (NUM_STAGES-1-k)*(BITS_PER_STAGE-REDUNDANCY) + BITS_LAST - REDUNDANCY;
  endfunction

  function automatic logic [IW-1:0] weigh(input logic [BITS_PER_STAGE-1:0] code, input int k);
    return IW'(code) << shift_of(k);
  endfunction

  // Result packing: {clipped, value}.
`ifdef ADC_PIPE_CORR_OFFSET_EN
  function automatic logic [NUM_BITS:0] saturate(input logic signed [SW-1:0] s);
    if (s < 0)
      return {1'b1, {NUM_BITS{1'b0}}};
    else if (s[NUM_BITS])
      return {1'b1, {NUM_BITS{1'b1}}};
    else
      return {1'b0, s[NUM_BITS-1:0]};
  endfunction
`else
  function automatic logic [NUM_BITS:0] saturate(input logic [IW-1:0] s);
    if (s[NUM_BITS])
      return {1'b1, {NUM_BITS{1'b1}}};
    else
      return {1'b0, s[NUM_BITS-1:0]};
  endfunction
`endif

  logic [IW-1:0]         wcode [NUM_STAGES];
  logic [IW-1:0]         sum_p [NUM_STAGES];
  logic [NUM_STAGES-1:0] vld_p;
  logic [NUM_BITS:0]     sat_res;

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++)
      wcode[k] = weigh(d_stage_i[k*BITS_PER_STAGE +: BITS_PER_STAGE], k);
  end

  // Stage boundaries p0..p(NUM_STAGES-1): each stage folds in its own code one cycle later.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      vld_p <= '0;
      for (int k = 0; k < NUM_STAGES; k++)
        sum_p[k] <= '0;
    end else begin
      vld_p[0] <= valid_i;
      if (valid_i)
        sum_p[0] <= wcode[0];
      for (int k = 1; k < NUM_STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1])
          sum_p[k] <= sum_p[k-1] + wcode[k];
      end
    end
  end

`ifdef ADC_PIPE_CORR_OFFSET_EN
  logic signed [SW-1:0] sum_fin;
  assign sum_fin = $signed({1'b0, sum_p[NUM_STAGES-1]}) + $signed(SW'(d_last_stage_i))
                 + SW'(offset_i);
`else
  logic [IW-1:0] sum_fin;
  assign sum_fin = sum_p[NUM_STAGES-1] + IW'(d_last_stage_i);
`endif

  assign sat_res = saturate(sum_fin);

  // Output boundary: final flash code added, result clipped and counted.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_o   <= 1'b0;
      d_o       <= '0;
      sat_o     <= 1'b0;
      sat_cnt_o <= '0;
    end else begin
      valid_o <= vld_p[NUM_STAGES-1];
      if (vld_p[NUM_STAGES-1]) begin
        sat_o <= sat_res[NUM_BITS];
        d_o   <= sat_res[NUM_BITS-1:0];
      end
      if (clr_cnt_i)
        sat_cnt_o <= '0;
      else if (vld_p[NUM_STAGES-1] && sat_res[NUM_BITS] && sat_cnt_o != CNT_MAX)
        sat_cnt_o <= sat_cnt_o + 1'b1;
    end
  end

endmodule
